// File: rtl/local_sram_arbiter.sv
// local_sram_arbiter: shares the single-ported local SRAM between the host,
// the Searcher and the Updater. Arbitration is round-robin with a bounded
// burst hold. The host can take exclusive ownership through a one-cycle drain.
// Optional statistics counters are built when LOCAL_SRAM_ARB_STATS_EN is defined.
module local_sram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    csr_host_lock,
    output logic                    csr_host_owned,
    input  logic [2:0]              req_i,
    input  logic [2:0]              we_i,
    input  logic [3*ADDR_WIDTH-1:0] addr_i,
    input  logic [3*DATA_WIDTH-1:0] wdata_i,
    output logic [2:0]              gnt_o,
    output logic [2:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   sram_rdata_i,
    output logic [3*32-1:0]         stat_gnt_cnt,
    output logic [31:0]             stat_conflict_cnt
);

    typedef enum logic [1:0] {ST_ARB, ST_DRAIN, ST_HOST} state_t;

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic [2:0] gnt_raw;
    logic [2:0] rvalid_q;
    logic [1:0] nxt1, nxt2;

    // Round-robin search order after the current owner.
    always_comb begin
        nxt1 = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
        nxt2 = (owner == 2'd0) ? 2'd2 : owner - 2'd1;
    end

    // State, owner and burst counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ARB;
            owner     <= 2'd1;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Next-state and grant selection. burst_cnt == 0 means no burst in progress,
    // so the owner only keeps priority while it is actively bursting; after an
    // idle cycle or reset the search starts at owner+1.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        gnt_raw   = '0;
        unique case (state)
            ST_ARB: begin
                if (csr_host_lock) state_nxt = ST_DRAIN;
                if (req_i[owner] && burst_cnt != 4'd0 && burst_cnt < 4'(MAX_BURST)) begin
                    gnt_raw[owner] = 1'b1;
                    burst_nxt      = burst_cnt + 4'd1;
                end else if (req_i[nxt1]) begin
                    gnt_raw[nxt1] = 1'b1;
                    owner_nxt     = nxt1;
                    burst_nxt     = 4'd1;
                end else if (req_i[nxt2]) begin
                    gnt_raw[nxt2] = 1'b1;
                    owner_nxt     = nxt2;
                    burst_nxt     = 4'd1;
                end else if (req_i[owner]) begin
                    gnt_raw[owner] = 1'b1;
                    burst_nxt      = 4'd1;
                end else begin
                    burst_nxt = 4'd0;
                end
            end
            ST_DRAIN: begin
                state_nxt = csr_host_lock ? ST_HOST : ST_ARB;
            end
            ST_HOST: begin
                if (!csr_host_lock) state_nxt = ST_ARB;
                gnt_raw[0] = req_i[0];
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    assign gnt_o          = rst_n ? gnt_raw : '0;
    assign csr_host_owned = (state == ST_HOST);

    // SRAM port mux driven by the granted requester, zero when idle.
    always_comb begin
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            if (gnt_o[r]) begin
                sram_we_o    = we_i[r];
                sram_addr_o  = addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
                sram_wdata_o = wdata_i[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sram_req_o = |gnt_o;

    // Read return tag: one cycle after a granted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rvalid_q <= '0;
        else        rvalid_q <= gnt_o & ~we_i;
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = (|rvalid_q) ? sram_rdata_i : '0;

`ifdef LOCAL_SRAM_ARB_STATS_EN
    logic [31:0] gnt_cnt [3];
    logic [31:0] conflict_cnt;
    logic        conflict;

    assign conflict = (req_i[0] & req_i[1]) | (req_i[0] & req_i[2]) | (req_i[1] & req_i[2]);

    // Grant and conflict statistics, free-running and wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < 3; r++) gnt_cnt[r] <= '0;
            conflict_cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < 3; r++)
                if (gnt_o[r]) gnt_cnt[r] <= gnt_cnt[r] + 32'd1;
            if (conflict) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    assign stat_gnt_cnt      = {gnt_cnt[2], gnt_cnt[1], gnt_cnt[0]};
    assign stat_conflict_cnt = conflict_cnt;
`else
    assign stat_gnt_cnt      = '0;
    assign stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_local_sram_arbiter.sv
// Directed self-checking bench for local_sram_arbiter with a 1-cycle SRAM model.
module tb_local_sram_arbiter;

`ifdef LOCAL_SRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [63:0] D_HOST = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] D_SRCH = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] D_UPD  = 64'hCAFE_0000_0000_0030;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_host_lock;
    logic        csr_host_owned;
    logic [2:0]  req_i, we_i, gnt_o, rvalid_o;
    logic [29:0] addr_i;
    logic [191:0] wdata_i;
    logic [63:0] rdata_o, sram_wdata_o, sram_rdata_i;
    logic        sram_req_o, sram_we_o;
    logic [9:0]  sram_addr_o;
    logic [95:0] stat_gnt_cnt;
    logic [31:0] stat_conflict_cnt;

    logic [63:0] mem [0:1023];
    int errors = 0;
    int checks = 0;
    logic [2:0] exp_seq [12];
    logic [2:0] prev_g;

    local_sram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .csr_host_lock(csr_host_lock), .csr_host_owned(csr_host_owned),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .stat_gnt_cnt(stat_gnt_cnt), .stat_conflict_cnt(stat_conflict_cnt)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous write, registered read.
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
            else           sram_rdata_i     <= mem[sram_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic l);
        @(negedge clk);
        req_i = r; we_i = w; csr_host_lock = l;
        #1;
    endtask

    function automatic logic [63:0] data_for(input logic [2:0] g);
        case (g)
            3'b001:  return D_HOST;
            3'b010:  return D_SRCH;
            3'b100:  return D_UPD;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk_stats(input string tag, input int h, input int s, input int u, input int c);
        chk({tag, "_gnt_host"}, 64'(stat_gnt_cnt[31:0]),  STATS ? 64'(h) : 64'd0);
        chk({tag, "_gnt_srch"}, 64'(stat_gnt_cnt[63:32]), STATS ? 64'(s) : 64'd0);
        chk({tag, "_gnt_upd"},  64'(stat_gnt_cnt[95:64]), STATS ? 64'(u) : 64'd0);
        chk({tag, "_conflict"}, 64'(stat_conflict_cnt),   STATS ? 64'(c) : 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h010] = D_SRCH;
        mem[10'h030] = D_UPD;
        sram_rdata_i = '0;
        addr_i  = {10'h030, 10'h010, 10'h020};
        wdata_i = {64'd0, 64'd0, D_HOST};
        rst_n = 1'b0; req_i = 3'b111; we_i = '0; csr_host_lock = 1'b0;

        // Reset state with all requesters asking
        @(negedge clk); @(negedge clk); #1;
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_sram_req", 64'(sram_req_o), 64'd0);
        chk("rst_sram_addr", 64'(sram_addr_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_owned", 64'(csr_host_owned), 64'd0);
        chk_stats("rst", 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1; req_i = '0;

        // Single searcher read
        drive(3'b010, 3'b000, 1'b0);
        chk("s1_gnt", 64'(gnt_o), 64'(3'b010));
        chk("s1_sram_req", 64'(sram_req_o), 64'd1);
        chk("s1_sram_addr", 64'(sram_addr_o), 64'h010);
        chk("s1_sram_we", 64'(sram_we_o), 64'd0);
        drive(3'b000, 3'b000, 1'b0);
        chk("s1_gnt_idle", 64'(gnt_o), 64'd0);
        chk("s1_rvalid", 64'(rvalid_o), 64'(3'b010));
        chk("s1_rdata", rdata_o, D_SRCH);
        drive(3'b000, 3'b000, 1'b0);
        chk("s1_rvalid_once", 64'(rvalid_o), 64'd0);
        chk("s1_rdata_zero", rdata_o, 64'd0);

        // Host write then read back
        drive(3'b001, 3'b001, 1'b0);
        chk("wr_gnt", 64'(gnt_o), 64'(3'b001));
        chk("wr_sram_we", 64'(sram_we_o), 64'd1);
        chk("wr_sram_wdata", sram_wdata_o, D_HOST);
        drive(3'b001, 3'b000, 1'b0);
        chk("wr_no_rvalid", 64'(rvalid_o), 64'd0);
        chk("rd_gnt", 64'(gnt_o), 64'(3'b001));
        drive(3'b000, 3'b000, 1'b0);
        chk("rd_rvalid", 64'(rvalid_o), 64'(3'b001));
        chk("rd_rdata", rdata_o, D_HOST);

        // Searcher and updater contend: bursts of four
        exp_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100,
                    3'b010, 3'b010, 3'b010, 3'b010};
        prev_g = 3'b000;
        for (int k = 0; k < 12; k++) begin
            drive(3'b110, 3'b000, 1'b0);
            chk($sformatf("s2_gnt%0d", k), 64'(gnt_o), 64'(exp_seq[k]));
            chk($sformatf("s2_rvalid%0d", k), 64'(rvalid_o), 64'(prev_g));
            if (k == 8) chk("s2_conflict8", 64'(stat_conflict_cnt), STATS ? 64'd8 : 64'd0);
            prev_g = exp_seq[k];
        end
        drive(3'b000, 3'b000, 1'b0);
        chk("s2_rdata_last", rdata_o, D_SRCH);
        chk_stats("s2", 2, 9, 4, 12);

        // Updater alone for 10 cycles: no bubbles across burst expiry
        prev_g = 3'b000;
        for (int k = 0; k < 10; k++) begin
            drive(3'b100, 3'b000, 1'b0);
            chk($sformatf("s5_gnt%0d", k), 64'(gnt_o), 64'(3'b100));
            chk($sformatf("s5_rvalid%0d", k), 64'(rvalid_o), 64'(prev_g));
            prev_g = 3'b100;
        end
        drive(3'b000, 3'b000, 1'b0);
        chk("s5_rdata_last", rdata_o, D_UPD);

        // Host lock rising with a searcher read in the same cycle
        drive(3'b010, 3'b000, 1'b1);
        chk("s4_gnt_n", 64'(gnt_o), 64'(3'b010));
        chk("s4_owned_n", 64'(csr_host_owned), 64'd0);
        drive(3'b111, 3'b000, 1'b1);
        chk("s4_drain_gnt", 64'(gnt_o), 64'd0);
        chk("s4_drain_sram_req", 64'(sram_req_o), 64'd0);
        chk("s4_drain_rvalid", 64'(rvalid_o), 64'(3'b010));
        chk("s4_drain_rdata", rdata_o, D_SRCH);
        chk("s4_drain_owned", 64'(csr_host_owned), 64'd0);
        drive(3'b111, 3'b000, 1'b1);
        chk("s4_host_gnt", 64'(gnt_o), 64'(3'b001));
        chk("s4_host_addr", 64'(sram_addr_o), 64'h020);
        chk("s4_host_owned", 64'(csr_host_owned), 64'd1);
        drive(3'b110, 3'b000, 1'b1);
        chk("s4_engines_blocked", 64'(gnt_o), 64'd0);
        chk("s4_host_rvalid", 64'(rvalid_o), 64'(3'b001));
        chk("s4_host_rdata", rdata_o, D_HOST);
        drive(3'b110, 3'b000, 1'b0);
        chk("s4_unlock_gnt", 64'(gnt_o), 64'd0);
        chk("s4_unlock_owned", 64'(csr_host_owned), 64'd1);
        drive(3'b110, 3'b000, 1'b0);
        chk("s4_resume_owned", 64'(csr_host_owned), 64'd0);
        chk("s4_resume_frozen", 64'(gnt_o), 64'(3'b010));
        drive(3'b000, 3'b000, 1'b0);
        chk("s4_resume_rvalid", 64'(rvalid_o), 64'(3'b010));

        // Lock dropping during DRAIN returns to ARB
        drive(3'b000, 3'b000, 1'b1);
        drive(3'b100, 3'b000, 1'b0);
        chk("dr_abort_gnt", 64'(gnt_o), 64'd0);
        chk("dr_abort_owned", 64'(csr_host_owned), 64'd0);
        drive(3'b100, 3'b000, 1'b0);
        chk("dr_abort_arb_gnt", 64'(gnt_o), 64'(3'b100));
        drive(3'b000, 3'b000, 1'b0);

        // Reset pulse right after a host read grant
        drive(3'b001, 3'b000, 1'b0);
        chk("s6_host_gnt", 64'(gnt_o), 64'(3'b001));
        @(negedge clk);
        rst_n = 1'b0; req_i = 3'b111;
        #1;
        chk("s6_rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("s6_rst_rdata", rdata_o, 64'd0);
        chk("s6_rst_gnt", 64'(gnt_o), 64'd0);
        chk_stats("s6_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; req_i = '0;
        #1;
        chk("s6_post_rvalid", 64'(rvalid_o), 64'd0);
        chk("s6_post_owned", 64'(csr_host_owned), 64'd0);

        // All three from reset: updater, host, searcher bursts
        exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001,
                    3'b010, 3'b010, 3'b010, 3'b010};
        prev_g = 3'b000;
        for (int k = 0; k < 12; k++) begin
            drive(3'b111, 3'b000, 1'b0);
            chk($sformatf("s3_gnt%0d", k), 64'(gnt_o), 64'(exp_seq[k]));
            chk($sformatf("s3_rdata%0d", k), rdata_o, data_for(prev_g));
            prev_g = exp_seq[k];
        end
        drive(3'b000, 3'b000, 1'b0);
        chk("s3_rvalid_last", 64'(rvalid_o), 64'(3'b010));
        chk_stats("s3", 4, 4, 4, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
